add_seq_ctrl: RTL

Sequencing controller that shares one external 16-bit carry-lookahead adder between two requesters. It arbitrates round-robin, drives the adder's operands and carry-in, and runs 16-bit ops in one adder pass and 32-bit ops in two passes (low half, then high half with the carried-out bit). Results return through a registered valid/ready response port. The block sits between the ALU/address-generation clients and the shared adder instance.

---
 rtl/add_seq_ctrl_pkg.sv | 29 ++
 rtl/add_seq_ctrl_if.sv | 53 +++++
 rtl/add_seq_ctrl_rr_arb2.sv | 27 ++
 rtl/add_seq_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/add_seq_ctrl_pkg.sv
// Shared types and widths for the add-sequencing controller.
package add_seq_pkg;

    localparam int WORD_W  = 16;
    localparam int DWORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef logic req_id_t;

    typedef struct packed {
        logic [DWORD_W-1:0] a;
        logic [DWORD_W-1:0] b;
        logic               sub;
        logic               wide;
        req_id_t            id;
    } op_t;

    // Signed overflow of a two's-complement add, from the three MSBs involved.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/add_seq_ctrl_if.sv
// Request, shared-adder and response signals of add_seq_ctrl.
// master = clients/adder side, slave = the controller.
interface add_seq_ctrl_if;
    import add_seq_pkg::*;

    logic               req0_valid;
    logic               req0_ready;
    logic [DWORD_W-1:0] req0_a;
    logic [DWORD_W-1:0] req0_b;
    logic               req0_sub;
    logic               req0_wide;

    logic               req1_valid;
    logic               req1_ready;
    logic [DWORD_W-1:0] req1_a;
    logic [DWORD_W-1:0] req1_b;
    logic               req1_sub;
    logic               req1_wide;

    logic [WORD_W-1:0]  add_a;
    logic [WORD_W-1:0]  add_b;
    logic               add_cin;
    logic [WORD_W-1:0]  add_sum;
    logic               add_cout;

    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [DWORD_W-1:0] rsp_sum;
    logic               rsp_cout;
    logic               rsp_ovf;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub, req0_wide,
        output req1_valid, req1_a, req1_b, req1_sub, req1_wide,
        input  req0_ready, req1_ready,
        input  add_a, add_b, add_cin,
        output add_sum, add_cout,
        output rsp_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub, req0_wide,
        input  req1_valid, req1_a, req1_b, req1_sub, req1_wide,
        output req0_ready, req1_ready,
        output add_a, add_b, add_cin,
        input  add_sum, add_cout,
        input  rsp_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );

endinterface

// File: rtl/add_seq_ctrl_rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, priority flips away from each winner on i_adv.
module rr_arb2 #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_adv,
    output logic [1:0] o_gnt
);

    logic r_prio;

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11)
            o_gnt = r_prio ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_prio <= RR_INIT;
        else if (i_adv && (|o_gnt))
            r_prio <= o_gnt[0];
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// Shares one external 16-bit adder between two requesters; 32-bit ops take two passes.
// Define ADD_SEQ_OVF_EN to build the signed-overflow flag; otherwise rsp_ovf is tied to 0.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter bit RR_INIT = 1'b0
) (
    input logic         clk,
    input logic         rst,
    add_seq_ctrl_if.slave bus
);

    state_t             r_state, w_state_nxt;
    op_t                r_op, w_op_in;
    logic               r_carry;
    logic [WORD_W-1:0]  r_sum_lo;
    logic               r_rsp_valid;
    req_id_t            r_rsp_id;
    logic [DWORD_W-1:0] r_rsp_sum;
    logic               r_rsp_cout;
    logic [1:0]         w_req, w_gnt;
    logic               w_grant;
    logic [WORD_W-1:0]  w_add_a, w_add_b;
    logic               w_add_cin;

    assign w_req   = {bus.req1_valid, bus.req0_valid};
    assign w_grant = (r_state == IDLE) && !rst && (|w_req);

    rr_arb2 #(.RR_INIT(RR_INIT)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_req),
        .i_adv (w_grant),
        .o_gnt (w_gnt)
    );

    assign bus.req0_ready = w_grant && w_gnt[0];
    assign bus.req1_ready = w_grant && w_gnt[1];

    assign w_op_in = w_gnt[1]
        ? '{a: bus.req1_a, b: bus.req1_b, sub: bus.req1_sub, wide: bus.req1_wide, id: 1'b1}
        : '{a: bus.req0_a, b: bus.req0_b, sub: bus.req0_sub, wide: bus.req0_wide, id: 1'b0};

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_add_a     = '0;
        w_add_b     = '0;
        w_add_cin   = 1'b0;
        case (r_state)
            IDLE: if (w_grant) w_state_nxt = LO;
            LO: begin
                w_add_a     = r_op.a[WORD_W-1:0];
                w_add_b     = r_op.sub ? ~r_op.b[WORD_W-1:0] : r_op.b[WORD_W-1:0];
                w_add_cin   = r_op.sub;
                w_state_nxt = r_op.wide ? HI : RESP;
            end
            HI: begin
                w_add_a     = r_op.a[DWORD_W-1:WORD_W];
                w_add_b     = r_op.sub ? ~r_op.b[DWORD_W-1:WORD_W] : r_op.b[DWORD_W-1:WORD_W];
                w_add_cin   = r_carry;
                w_state_nxt = RESP;
            end
            RESP: if (bus.rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.add_a   = w_add_a;
    assign bus.add_b   = w_add_b;
    assign bus.add_cin = w_add_cin;

    // Operand latch and inter-pass carry; only meaningful while an op is in flight.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_grant)
            r_op <= w_op_in;
        if (r_state == LO || r_state == HI) begin
            r_carry <= bus.add_cout;
            if (r_state == LO)
                r_sum_lo <= bus.add_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
        end else begin
            if (r_state == LO && !r_op.wide) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_op.id;
                r_rsp_sum   <= {{WORD_W{1'b0}}, bus.add_sum};
                r_rsp_cout  <= bus.add_cout;
            end else if (r_state == HI) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_op.id;
                r_rsp_sum   <= {bus.add_sum, r_sum_lo};
                r_rsp_cout  <= bus.add_cout;
            end else if (r_state == RESP && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_sum   = r_rsp_sum;
    assign bus.rsp_cout  = r_rsp_cout;

`ifdef ADD_SEQ_OVF_EN
    logic r_rsp_ovf;

    // Final pass is LO for narrow ops and HI for wide ops; the adder MSBs are bit 15 either way.
    always_ff @(posedge clk) begin
        if (rst)
            r_rsp_ovf <= 1'b0;
        else if ((r_state == LO && !r_op.wide) || r_state == HI)
            r_rsp_ovf <= ovf_calc(w_add_a[WORD_W-1], w_add_b[WORD_W-1], bus.add_sum[WORD_W-1]);
    end

    assign bus.rsp_ovf = r_rsp_ovf;
`else
    assign bus.rsp_ovf = 1'b0;
`endif

endmodule
